p2s: RTL and testbench
======================

Name: p2s

Overview:
- 64-bit parallel-to-serial transmitter. It is the sending end of the link that s2p receives.
- Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clk on serial_out.
- Drives enable_out high for exactly the bits of each word, so serial_out/enable_out connect directly to s2p serial_in/enable.
- Sits between a word-producing datapath and the serial link; supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 64, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  WIDTH  parallel word to transmit
- in_valid  input  1  data_in is valid
- in_ready  output  1  block will capture data_in this cycle if in_valid=1
- abort  input  1  synchronous; cancels the word in flight
- serial_out  output  1  serial data bit (registered)
- enable_out  output  1  high while serial_out carries a valid bit (registered)
- busy  output  1  high while a word is in flight
- done  output  1  one-cycle pulse coincident with the last bit of each word

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - serial_out=0, enable_out=0, busy=0, done=0, in_ready=0.
  - Shift register and bit counter clear to 0.
  - Takes effect immediately, including mid-word; the partial word is lost.
  - in_ready rises the first clk edge after rst_n deasserts.
- States: IDLE, SHIFT (2-bit encoding, from the package).
- IDLE:
  - in_ready=1, enable_out=0, serial_out=0.
  - On in_valid & in_ready at edge N: capture data_in, load cnt=WIDTH-1, go to SHIFT.
  - At edge N the first bit appears on serial_out and enable_out=1, so it is visible in cycle N+1 (one-cycle latency).
- SHIFT:
  - Each edge presents the next bit and decrements cnt.
  - The word occupies exactly WIDTH consecutive cycles with enable_out=1.
  - Last-bit cycle (cnt==0): done=1, and in_ready=1 (combinational: state==IDLE or (state==SHIFT and cnt==0 and !abort)).
  - If in_valid=1 on the last-bit cycle: the new word is captured, its first bit follows immediately, and enable_out stays high (no gap).
  - Otherwise go to IDLE; enable_out and serial_out drop to 0.
- Bit order:
  - MSB_FIRST=1: transmit data_in[WIDTH-1] down to data_in[0].
  - MSB_FIRST=0: transmit data_in[0] up to data_in[WIDTH-1].
- busy = (state==SHIFT).
- Data stability: data_in is sampled only on the accepting edge; later changes to data_in have no effect.
- Abort:
  - abort=1 in SHIFT: at the next edge go to IDLE with enable_out=0, serial_out=0, done not asserted, and in_ready=0 for that cycle.
  - abort in IDLE is ignored.
  - abort together with in_valid on the last-bit cycle: abort wins, the word is not accepted, and done is suppressed.
- in_valid while not in_ready: no capture. The producer must hold in_valid until in_ready.
- Counter: $clog2(WIDTH) bits, never wraps; reaching 0 ends the word.

Decomposition:
- Package p2s_pkg holds:
  - state typedef/localparams ST_IDLE=2'd0, ST_SHIFT=2'd1
  - DEFAULT_WIDTH=64
  - a function returning the bit index for a given count and MSB_FIRST
- One sub-module, p2s_bit_counter: a loadable down-counter with a zero flag.
- The shift register and FSM stay in p2s.

Test Plan:
- Reset then idle: hold rst_n=0 for 5 cycles, then release → all outputs 0 during reset; in_ready=1 one edge after release; serial_out=0 and enable_out=0 while idle.
- Single word, MSB_FIRST=1, data_in=64'hA5A5_0000_FFFF_1234, one-cycle in_valid →
  - enable_out high for exactly 64 cycles, starting the cycle after acceptance
  - first bits 1,0,1,0,0,1,0,1; last four bits 0,1,0,0
  - done high only on cycle 64; busy falls after that
- Back-to-back: present 64'h1 then 64'h8000_0000_0000_0000, with in_valid held on the last-bit cycle → 128 contiguous enable_out cycles with no gap; bit 64 = 1, bit 65 = 1, all other bits 0; two done pulses 64 cycles apart.
- Abort: abort=1 at bit 20 of a word → enable_out=0 the next cycle, no done pulse, in_ready=0 for that cycle and 1 afterwards; a new word sends correctly.
- Async reset mid-word: drop rst_n at bit 30, asynchronously to clk → outputs 0 immediately without waiting for an edge; after release, the next word transmits in full.
- Loopback: p2s serial_out/enable_out connected to s2p serial_in/enable, word 64'hDEAD_BEEF_0123_4567 → s2p data_valid asserts with data_out = 64'hDEAD_BEEF_0123_4567; repeat with MSB_FIRST matched to s2p bit order.

Source files
------------

// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared state encoding, defaults and bit-order helper for p2s
package p2s_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;

  // Bit of the word presented while the down-counter holds cnt.
  function automatic int unsigned bit_index(input int unsigned cnt,
                                            input int unsigned width,
                                            input logic        msb_first);
    return msb_first ? cnt : (width - 32'd1 - cnt);
  endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// rtl/p2s_bit_counter.sv - loadable down-counter with zero flag; holds at zero
module p2s_bit_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/p2s.sv
// rtl/p2s.sv - parallel-to-serial transmitter with valid/ready input and abort
module p2s
  import p2s_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             serial_out,
  output logic             enable_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] sel;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             ready_en;
  logic             last_bit;
  logic             accept;
  logic             load;
  logic             dec;
  logic             so_nxt;
  logic             en_nxt;

  p2s_bit_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (CW'(WIDTH - 1)),
    .dec        (dec),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // ready_en keeps in_ready low for the first cycle out of reset and after an abort.
  assign last_bit = (state == ST_SHIFT) && cnt_zero;
  assign in_ready = ready_en && ((state == ST_IDLE) || (last_bit && !abort));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_SHIFT);
  assign done     = last_bit && !abort;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    so_nxt    = 1'b0;
    en_nxt    = 1'b0;
    sel       = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (!cnt_zero) dec = 1'b1;
        else if (accept)    load = 1'b1;
        else                state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // The first bit comes straight from data_in so it appears on the accepting edge.
    if (load) begin
      sel    = data_in >> bit_index(WIDTH - 1, WIDTH, MSB_FIRST);
      so_nxt = sel[0];
      en_nxt = 1'b1;
    end else if (dec) begin
      sel    = word_q >> bit_index(32'(cnt) - 32'd1, WIDTH, MSB_FIRST);
      so_nxt = sel[0];
      en_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_q     <= '0;
      serial_out <= 1'b0;
      enable_out <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= state_nxt;
      serial_out <= so_nxt;
      enable_out <= en_nxt;
      ready_en   <= !((state == ST_SHIFT) && abort);
      if (load) word_q <= data_in;
    end
  end

endmodule

// File: tb/tb_p2s.sv
// tb/tb_p2s.sv - self-checking bench for p2s with a bit-collecting receiver model
module tb_p2s;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data_in = '0;
  logic        in_valid = 1'b0;
  logic        abort = 1'b0;
  logic        in_ready, serial_out, enable_out, busy, done;

  logic [7:0]  data8 = '0;
  logic        valid8 = 1'b0;
  logic        ready8, so8, en8, busy8, done8;

  int n_vec = 0;
  int n_err = 0;

  p2s #(.WIDTH(64), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .serial_out(serial_out),
    .enable_out(enable_out), .busy(busy), .done(done)
  );

  p2s #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(data8), .in_valid(valid8),
    .in_ready(ready8), .abort(1'b0), .serial_out(so8),
    .enable_out(en8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic en;
    logic so;
  } smp_t;

  smp_t trace[$];
  logic mon = 1'b0;

  always @(negedge clk) begin
    if (mon) trace.push_back({in_ready, busy, done, enable_out, serial_out});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic smp_t at(input int i);
    if (i >= 0 && i < trace.size()) return trace[i];
    return '0;
  endfunction

  function automatic int cnt_en();
    int n = 0;
    foreach (trace[i]) if (trace[i].en === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_done();
    int n = 0;
    foreach (trace[i]) if (trace[i].done === 1'b1) n++;
    return n;
  endfunction

  function automatic int nth_done(input int k);
    int seen = 0;
    foreach (trace[i]) begin
      if (trace[i].done === 1'b1) begin
        if (seen == k) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  // Receiver model: first received bit ends up most significant.
  function automatic logic [63:0] rx(input int a, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[62:0], at(a + i).so};
    return r;
  endfunction

  task automatic start_word(input logic [63:0] w);
    int t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", in_ready, 1);
    #1;
    data_in  = w;
    in_valid = 1'b1;
    trace.delete();
    mon = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom};
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1 mon = 1'b0;
  endtask

  logic [63:0] w, w2;
  logic [7:0]  b, got;
  int          ne, dpos, t;

  initial begin
    // Reset and idle
    in_valid = 1'b1;
    data_in  = {$urandom, $urandom};
    repeat (5) begin
      @(negedge clk);
      chk("rst_outs", {in_ready, busy, done, enable_out, serial_out}, 0);
    end
    #2 rst_n = 1'b1;
    #1 chk("rdy_before_edge", in_ready, 0);
    @(negedge clk);
    chk("rdy_after_edge", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_en", {enable_out, serial_out}, 0);
    #1 in_valid = 1'b0;

    // Single word
    start_word(64'hA5A5_0000_FFFF_1234);
    run(66);
    chk("single_word", rx(0, 64), 64'hA5A5_0000_FFFF_1234);
    chk("single_first8", rx(0, 8), 64'hA5);
    chk("single_last4", rx(60, 4), 64'h4);
    chk("single_en_cnt", cnt_en(), 64);
    chk("single_en_first", at(0).en, 1);
    chk("single_en_last", {at(63).en, at(64).en}, 2'b10);
    chk("single_done_cnt", cnt_done(), 1);
    chk("single_done_pos", nth_done(0), 63);
    chk("single_busy", {at(63).busy, at(64).busy}, 2'b10);

    // Back-to-back
    start_word(64'h1);
    t = 0;
    @(negedge clk);
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_done_seen", done, 1);
    chk("b2b_ready_last", in_ready, 1);
    #1;
    data_in  = 64'h8000_0000_0000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom};
    run(70);
    chk("b2b_en_cnt", cnt_en(), 128);
    chk("b2b_en_end", {at(127).en, at(128).en}, 2'b10);
    chk("b2b_word0", rx(0, 64), 64'h1);
    chk("b2b_word1", rx(64, 64), 64'h8000_0000_0000_0000);
    chk("b2b_bits64_65", rx(63, 2), 64'h3);
    chk("b2b_done_cnt", cnt_done(), 2);
    chk("b2b_done0", nth_done(0), 63);
    chk("b2b_done1", nth_done(1), 127);

    // Abort at bit 20, then a word held while not ready
    w  = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    start_word(w);
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    data_in  = w2;
    in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom};
    run(70);
    chk("abort_bits", rx(0, 20), w >> 44);
    chk("abort_en", {at(19).en, at(20).en, at(21).en, at(22).en}, 4'b1001);
    chk("abort_so", at(20).so, 0);
    chk("abort_ready", {at(20).ready, at(21).ready}, 2'b01);
    chk("abort_busy", at(20).busy, 0);
    chk("abort_next_word", rx(22, 64), w2);
    chk("abort_en_cnt", cnt_en(), 84);
    chk("abort_done_cnt", cnt_done(), 1);
    chk("abort_done_pos", nth_done(0), 85);

    // Asynchronous reset mid-word
    w = {$urandom, $urandom};
    start_word(w);
    repeat (29) @(posedge clk);
    #2 chk("areset_pre_en", enable_out, 1);
    #1 rst_n = 1'b0;
    #1 chk("areset_outs", {in_ready, busy, done, enable_out, serial_out}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    w = {$urandom, $urandom};
    start_word(w);
    run(66);
    chk("areset_next_word", rx(0, 64), w);
    chk("areset_next_len", cnt_en(), 64);

    // Loopback words
    for (int k = 0; k < 6; k++) begin
      w = (k == 0) ? 64'hDEAD_BEEF_0123_4567 : {$urandom, $urandom};
      start_word(w);
      run(65);
      chk("loop_word", rx(0, 64), w);
      chk("loop_len", cnt_en(), 64);
      chk("loop_done_pos", nth_done(0), 63);
    end

    // LSB-first, 8-bit instance
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk("lsb_ready", ready8, 1);
      #1;
      data8  = b;
      valid8 = 1'b1;
      @(posedge clk);
      #1;
      valid8 = 1'b0;
      data8  = ~b;
      got  = '0;
      ne   = 0;
      dpos = -1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (en8 === 1'b1) ne++;
        got[i] = so8;
        if (done8 === 1'b1) dpos = i;
      end
      @(negedge clk);
      chk("lsb_en_after", en8, 0);
      chk("lsb_word", got, b);
      chk("lsb_len", ne, 8);
      chk("lsb_done_pos", dpos, 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
